dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between two requesters: port 0 is the core's memory-access stage (LW/SW), port 1 is the debug/loader port used to preload or inspect data memory.
- Uses a two-way round-robin arbiter and a 3-state FSM.
- Issues registered memory-side enables and returns a one-cycle ready pulse with read data to the granted requester.
- Sits between the core memory-access stage, the debug port and the data-memory array.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Requester IDs
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Data-memory geometry in words
    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_SIZE   = 1 << DMEM_ADDR_W;

    // A word access must have its two low byte-address bits clear
    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie, the port not served last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       valid
);

    // Single requester wins outright; a tie goes to the other port than last time
    always_comb begin
        gnt   = 1'b0;
        valid = |req;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and debug/loader (port 1); DMEM_ARB_ALIGN_CHK_EN adds misalignment errors.
// Latency: request seen in IDLE at edge N -> mem_en in cycle N+1 -> ready pulse in cycle N+2; one access per 3 cycles.
// Backpressure: a requester holds req/we/addr/wdata stable until its ready pulse; stall = req & ~ready.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ready0,
    output logic [DATA_W-1:0] rdata0,
    output logic              stall0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ready1,
    output logic [DATA_W-1:0] rdata1,
    output logic              stall1,
`ifdef DMEM_ARB_ALIGN_CHK_EN
    output logic              err0,
    output logic              err1,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_n;
    logic              gnt, gnt_n;
    logic              last_grant, last_grant_n;
    logic              mem_en_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    // Per-access copies so the response does not depend on the requester
    // still driving its signals during RESP
    logic              op_we, op_we_n;
    logic [DATA_W-1:0] op_wdata, op_wdata_n;
    logic              op_mis, op_mis_n;

    logic              pick_gnt, pick_vld;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_mis;
    logic              in_resp;
    logic [DATA_W-1:0] resp_data;
    logic              unused_addr_bits;

    rr_arb2 u_rr_arb2 (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .valid      (pick_vld)
    );

    assign sel_we    = pick_gnt ? we1    : we0;
    assign sel_addr  = pick_gnt ? addr1  : addr0;
    assign sel_wdata = pick_gnt ? wdata1 : wdata0;

    // Upper bits wrap modulo memory depth; low bits are byte offsets
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign sel_mis = is_misaligned(sel_addr);
`else
    assign sel_mis = 1'b0;
`endif

    // State and memory-side strobe registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ARB_IDLE;
            gnt        <= REQ_CORE;
            last_grant <= REQ_DBG;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            op_we      <= 1'b0;
            op_wdata   <= '0;
            op_mis     <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            last_grant <= last_grant_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            op_we      <= op_we_n;
            op_wdata   <= op_wdata_n;
            op_mis     <= op_mis_n;
        end
    end

    // Next-state logic: grant in IDLE, strobe for one cycle, respond, repeat
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        last_grant_n = last_grant;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        op_we_n      = op_we;
        op_wdata_n   = op_wdata;
        op_mis_n     = op_mis;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_n       = pick_gnt;
                    // A misaligned access still walks the FSM but never touches memory
                    mem_en_n    = ~sel_mis;
                    mem_we_n    = sel_we & ~sel_mis;
                    mem_addr_n  = sel_addr[ADDR_W+1:2];
                    mem_wdata_n = sel_wdata;
                    op_we_n     = sel_we;
                    op_wdata_n  = sel_wdata;
                    op_mis_n    = sel_mis;
                    state_n     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                state_n = ARB_RESP;
            end
            ARB_RESP: begin
                last_grant_n = gnt;
                state_n      = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    assign in_resp = (state == ARB_RESP);

    // Loads return memory data, stores echo their write data, errors return zero
    always_comb begin
        resp_data = '0;
        if (!op_mis) begin
            resp_data = op_we ? op_wdata : mem_rdata;
        end
    end

    assign ready0 = in_resp & (gnt == REQ_CORE);
    assign ready1 = in_resp & (gnt == REQ_DBG);
    assign rdata0 = ready0 ? resp_data : '0;
    assign rdata1 = ready1 ? resp_data : '0;
    assign stall0 = req0 & ~ready0;
    assign stall1 = req1 & ~ready1;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign err0 = ready0 & op_mis;
    assign err1 = ready1 & op_mis;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Latency: checks the 2-cycle request-to-ready path and 3-cycle spacing under contention.
// Backpressure: requesters hold their request until ready, as a core would.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RST;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ready0, ready1, stall0, stall1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic        err0, err1;
`endif

    logic [31:0] mem [0:1023];
    int          n_cmp;
    int          n_bad;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ready0    (ready0),
        .rdata0    (rdata0),
        .stall0    (stall0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ready1    (ready1),
        .rdata1    (rdata1),
        .stall1    (stall1),
`ifdef DMEM_ARB_ALIGN_CHK_EN
        .err0      (err0),
        .err1      (err1),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port memory: write and registered read on the strobe edge
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One complete access from an idle arbiter; entered and left at edge+1 in IDLE
    task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic [9:0] exp_ma, input string tag);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        #1;
        chk({tag, "_stall_c0"}, 32'(port ? stall1 : stall0), 32'd1);
        chk({tag, "_en_c0"}, 32'(mem_en), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_en_c1"}, 32'(mem_en), 32'd1);
        chk({tag, "_we_c1"}, 32'(mem_we), 32'(we));
        chk({tag, "_maddr_c1"}, 32'(mem_addr), 32'(exp_ma));
        if (we) chk({tag, "_mwdata_c1"}, mem_wdata, wdata);
        chk({tag, "_stall_c1"}, 32'(port ? stall1 : stall0), 32'd1);
        chk({tag, "_rdy_c1"}, 32'({ready1, ready0}), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_rdy_c2"}, 32'({ready1, ready0}), port ? 32'd2 : 32'd1);
        chk({tag, "_rdata_c2"}, port ? rdata1 : rdata0, exp_rdata);
        chk({tag, "_other_rdata_c2"}, port ? rdata0 : rdata1, 32'd0);
        chk({tag, "_stall_c2"}, 32'(port ? stall1 : stall0), 32'd0);
        chk({tag, "_en_c2"}, 32'({mem_en, mem_we}), 32'd0);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        @(posedge CLK); #1;
        chk({tag, "_rdy_c3"}, 32'({ready1, ready0}), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_rdy;
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Everything quiet under reset
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_strobes", 32'({mem_en, mem_we}), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        chk("rst_ready", 32'({ready1, ready0}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Basic load, store with echo, and readback
        mem[5] = 32'hDEADBEEF;
        mem[1] = 32'h0BADF00D;
        do_access(1'b0, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 10'd5, "ld5");
        do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h12345678, 10'd8, "st8");
        chk("mem8_written", mem[8], 32'h12345678);
        do_access(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 10'd8, "ld8");

        // Upper address bits wrap: 0x1004 -> word 1
        do_access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'h0BADF00D, 10'd1, "wrap");

        // Contention: debug was served last, so the core goes first, then alternate
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("cont_rdy", 32'({ready1, ready0}), 32'(exp_rdy));
            if (exp_rdy == 2'b01) chk("cont_rdata0", rdata0, 32'hDEADBEEF);
            if (exp_rdy == 2'b10) chk("cont_rdata1", rdata1, 32'h0BADF00D);
            if (c < 11) @(posedge CLK);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge CLK); #1;
        chk("cont_idle", 32'({mem_en, ready1, ready0}), 32'd0);

        // Reset during ACCESS of a store to word 3, before its strobe edge
        mem[3] = 32'h33333333;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0C; wdata0 = 32'hFFFFFFFF;
        @(posedge CLK); #1;
        chk("rmid_en", 32'({mem_en, mem_we}), 32'd3);
        chk("rmid_maddr", 32'(mem_addr), 32'd3);
        RST = 1'b1;
        #1;
        chk("rmid_strobes_cleared", 32'({mem_en, mem_we}), 32'd0);
        chk("rmid_maddr_cleared", 32'(mem_addr), 32'd0);
        req0 = 1'b0; we0 = 1'b0; wdata0 = '0; addr0 = '0;
        @(posedge CLK); #1;
        chk("rmid_no_ready", 32'({ready1, ready0}), 32'd0);
        chk("rmid_rdata0", rdata0, 32'd0);
        chk("rmid_mem3_kept", mem[3], 32'h33333333);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rmid_idle", 32'({mem_en, ready1, ready0}), 32'd0);
        do_access(1'b0, 1'b0, 32'h0C, 32'h0, 32'h33333333, 10'd3, "post_rst");

`ifdef DMEM_ARB_ALIGN_CHK_EN
        // Misaligned core load: no strobe, error with ready at normal latency
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h22;
        #1;
        chk("mis_stall_c0", 32'(stall0), 32'd1);
        @(posedge CLK); #1;
        chk("mis_no_en", 32'({mem_en, mem_we}), 32'd0);
        chk("mis_err_c1", 32'({err1, err0}), 32'd0);
        @(posedge CLK); #1;
        chk("mis_ready0", 32'(ready0), 32'd1);
        chk("mis_err", 32'({err1, err0}), 32'd1);
        chk("mis_rdata0", rdata0, 32'd0);
        req0 = 1'b0;
        @(posedge CLK); #1;
        chk("mis_err_gone", 32'({err1, err0}), 32'd0);
`else
        // Low byte-offset bits are dropped: 0x22 reads word 8
        do_access(1'b0, 1'b0, 32'h22, 32'h0, 32'h12345678, 10'd8, "lowbits");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
